// File: rtl/reg_dump.sv
// reg_dump: debug readout engine for the register file.
// On start it walks registers 0..NUM_REGS-1 through a synchronous-read port
// and streams each one out MSB-first as bytes over a valid/ready link.
// Optional build macro: REG_DUMP_HEADER_EN. When it is defined, the stream
// begins with one 0xA5 header byte before the register data.
module reg_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int NBYTES = DATA_W / 8;
    localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    // idx carries one extra bit so the last-register compare never wraps
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_REGS - 1);
    localparam logic [7:0]      HDR_BYTE = 8'hA5;

`ifdef REG_DUMP_HEADER_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_REQ, S_CAP, S_SEND, S_FIN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_CAP, S_SEND, S_FIN} state_t;
`endif

    state_t              state_reg, state_next;
    logic [ADDR_W:0]     idx_reg, idx_next;
    logic [BC_W-1:0]     bytecnt_reg, bytecnt_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic [ADDR_W-1:0]   rf_addr_reg, rf_addr_next;

    // State register; reset aborts any dump in progress without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers: register index, byte counter, shift register, read address
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg     <= '0;
            bytecnt_reg <= '0;
            shift_reg   <= '0;
            rf_addr_reg <= '0;
        end else begin
            idx_reg     <= idx_next;
            bytecnt_reg <= bytecnt_next;
            shift_reg   <= shift_next;
            rf_addr_reg <= rf_addr_next;
        end
    end

    // Next-state and datapath update; every handshake-driven step waits on tx_ready
    // because tx_valid is unconditionally high in the byte-presenting states
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        bytecnt_next = bytecnt_reg;
        shift_next   = shift_reg;
        rf_addr_next = rf_addr_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    idx_next     = '0;
                    rf_addr_next = '0;
`ifdef REG_DUMP_HEADER_EN
                    state_next   = S_HDR;
`else
                    state_next   = S_REQ;
`endif
                end
            end
`ifdef REG_DUMP_HEADER_EN
            S_HDR: begin
                if (tx_ready) begin
                    state_next = S_REQ;
                end
            end
`endif
            // rf_addr is stable for this whole cycle; the register file samples it at the end
            S_REQ: begin
                state_next = S_CAP;
            end
            S_CAP: begin
                shift_next   = rf_data;
                bytecnt_next = BC_W'(NBYTES - 1);
                state_next   = S_SEND;
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (bytecnt_reg != '0) begin
                        shift_next   = shift_reg << 8;
                        bytecnt_next = bytecnt_reg - BC_W'(1);
                    end else if (idx_reg != LAST_IDX) begin
                        idx_next     = idx_reg + (ADDR_W + 1)'(1);
                        rf_addr_next = idx_next[ADDR_W-1:0];
                        state_next   = S_REQ;
                    end else begin
                        state_next   = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the current state; tx_data is zero whenever no byte is offered
    always_comb begin
        busy     = (state_reg != S_IDLE);
        done     = (state_reg == S_FIN);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rf_addr  = rf_addr_reg;
        if (state_reg == S_SEND) begin
            tx_valid = 1'b1;
            tx_data  = shift_reg[DATA_W-1 -: 8];
        end
`ifdef REG_DUMP_HEADER_EN
        if (state_reg == S_HDR) begin
            tx_valid = 1'b1;
            tx_data  = HDR_BYTE;
        end
`endif
    end

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: directed self-checking bench for reg_dump.
// Honours REG_DUMP_HEADER_EN so the same bench covers both builds.
module tb_reg_dump;

`ifdef REG_DUMP_HEADER_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif
    localparam int NBYTES_TOT = H + 128;
    localparam int DONE_CYC   = 193 + H;
    localparam int FIRST_VAL  = (H == 1) ? 1 : 3;
    localparam int MAX_CYC    = 5000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    logic [31:0] rf_mem [32];

    int checks   = 0;
    int failures = 0;

    // results gathered by drive_dump
    logic [7:0] byte_q [$];
    int         addr_trace [$];
    int         done_cnt, done_cyc, first_valid_cyc, stall_err, timed_out;
    logic       busy_after_done, busy_c1;

    reg_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    // synchronous-read register file model
    always @(posedge clk) rf_data <= rf_mem[rf_addr];

    function automatic logic [31:0] reg_val(input int r);
        if (r == 0)  return 32'h0;
        if (r == 1)  return 32'h12345678;
        if (r == 31) return 32'hDEADBEEF;
        return 32'(r);
    endfunction

    function automatic logic [7:0] exp_byte(input int k);
        logic [31:0] v;
        int j;
        if (H == 1 && k == 0) return 8'hA5;
        j = k - H;
        v = reg_val(j / 4);
        return v[(31 - 8 * (j % 4)) -: 8];
    endfunction

    // Runs one dump from start; ready_pct sets tx_ready duty, restart_at pulses
    // start when that many bytes have been taken, start_in_fin pulses start in FIN.
    task automatic drive_dump(input int ready_pct, input int restart_at, input bit start_in_fin);
        int   cyc;
        bit   prev_stall, restarted;
        logic [7:0] prev_data;
        byte_q.delete();
        addr_trace.delete();
        done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; stall_err = 0;
        timed_out = 0; busy_after_done = 1'b1; busy_c1 = 1'b0;
        prev_stall = 0; restarted = 0; prev_data = 8'h00;
        @(negedge clk); start = 1'b1; tx_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        while (1) begin
            addr_trace.push_back(int'(rf_addr));
            if (cyc == 1) busy_c1 = busy;
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_err++;
            if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            start = 1'b0;
            if (done_cnt > 0 && !done) begin
                busy_after_done = busy;
                break;
            end
            if (done && start_in_fin) start = 1'b1;
            if (restart_at >= 0 && !restarted && byte_q.size() == restart_at && tx_valid) begin
                start = 1'b1;
                restarted = 1;
            end
            tx_ready = ($urandom_range(0, 99) < ready_pct);
            if (tx_valid && tx_ready) byte_q.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (cyc >= MAX_CYC) begin
                timed_out = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        tx_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_after_done = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (rf_addr !== 5'd0) begin failures++; $display("FAIL reset_rf_addr got=%0d exp=0", rf_addr); end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic check_stream(input string tag);
        checks++; if (timed_out != 0) begin failures++; $display("FAIL %s_timeout got=%0d exp=0", tag, timed_out); end
        checks++; if (byte_q.size() != NBYTES_TOT) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", tag, byte_q.size(), NBYTES_TOT); end
        for (int k = 0; k < byte_q.size() && k < NBYTES_TOT; k++) begin
            checks++;
            if (byte_q[k] !== exp_byte(k)) begin
                failures++;
                $display("FAIL %s_byte%0d got=%h exp=%h", tag, k, byte_q[k], exp_byte(k));
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL %s_done_pulses got=%0d exp=1", tag, done_cnt); end
        checks++; if (busy_after_done !== 1'b0) begin failures++; $display("FAIL %s_busy_after_done got=%b exp=0", tag, busy_after_done); end
    endtask

    task automatic test_full_dump;
        drive_dump(100, -1, 1'b0);
        check_stream("full");
        checks++; if (busy_c1 !== 1'b1) begin failures++; $display("FAIL full_busy_c1 got=%b exp=1", busy_c1); end
        checks++; if (first_valid_cyc != FIRST_VAL) begin failures++; $display("FAIL full_first_valid got=%0d exp=%0d", first_valid_cyc, FIRST_VAL); end
        checks++; if (done_cyc != DONE_CYC) begin failures++; $display("FAIL full_done_cycle got=%0d exp=%0d", done_cyc, DONE_CYC); end
        // with no backpressure rf_addr must read i from cycle 6i+1+H onward
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (addr_trace.size() <= 6 * i + H || addr_trace[6 * i + H] != i) begin
                failures++;
                $display("FAIL full_rf_addr_step%0d got=%0d exp=%0d", i,
                         (addr_trace.size() > 6 * i + H) ? addr_trace[6 * i + H] : -1, i);
            end
        end
        checks++; if (rf_addr !== 5'd31) begin failures++; $display("FAIL full_rf_addr_hold got=%0d exp=31", rf_addr); end
        $display("test_full_dump done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_backpressure;
        int seq [$];
        drive_dump(30, -1, 1'b0);
        check_stream("bp");
        checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_err); end
        // distinct rf_addr values seen in order must be exactly 0..31
        foreach (addr_trace[i]) if (seq.size() == 0 || seq[$] != addr_trace[i]) seq.push_back(addr_trace[i]);
        checks++; if (seq.size() != 32) begin failures++; $display("FAIL bp_addr_seq_len got=%0d exp=32", seq.size()); end
        for (int i = 0; i < seq.size() && i < 32; i++) begin
            checks++;
            if (seq[i] != i) begin failures++; $display("FAIL bp_addr_seq%0d got=%0d exp=%0d", i, seq[i], i); end
        end
        $display("test_backpressure done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_restart_ignored;
        drive_dump(100, 49 + H, 1'b1);
        check_stream("restart");
        checks++; if (done_cyc != DONE_CYC) begin failures++; $display("FAIL restart_done_cycle got=%0d exp=%0d", done_cyc, DONE_CYC); end
        $display("test_restart_ignored done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_abort;
        int cnt = 0;
        int cyc = 0;
        bit hit = 0;
        int extra_done = 0;
        @(negedge clk); start = 1'b1; tx_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        while (cyc < 500) begin
            if (tx_valid && cnt == H + 21) begin
                hit = 1;
                break;
            end
            if (tx_valid) cnt++;
            @(negedge clk);
            cyc++;
        end
        checks++; if (!hit) begin failures++; $display("FAIL abort_reach_r5 got=%0d exp=%0d", cnt, H + 21); end
        checks++; if (tx_data !== 8'h34 - 8'h34 + exp_byte(H + 21)) begin failures++; $display("FAIL abort_r5_b1 got=%h exp=%h", tx_data, exp_byte(H + 21)); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL abort_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (rf_addr !== 5'd0) begin failures++; $display("FAIL abort_rf_addr got=%0d exp=0", rf_addr); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL abort_tx_data got=%h exp=00", tx_data); end
        if (done) extra_done++;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        checks++; if (extra_done != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", extra_done); end
        drive_dump(100, -1, 1'b0);
        check_stream("after_abort");
        $display("test_reset_abort done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf_mem[i] = reg_val(i);
        test_reset;
        test_full_dump;
        test_backpressure;
        test_restart_ignored;
        test_reset_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
